// File: rtl/pu_pkg.sv
// Shared types and default sizing for the PU memory arbiter.
package pu_pkg;

  localparam int NPU_DEF = 4;
  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 16;
  localparam int TO_DEF  = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches req starting just after last, returns a one-hot winner.
module rr_pick #(
  parameter int NPU = 4,
  parameter int LW  = 2
) (
  input  logic [NPU-1:0] req,
  input  logic [LW-1:0]  last,
  output logic [NPU-1:0] winner,
  output logic           valid
);

  logic [LW-1:0] idx;
  int            sum;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    sum    = 0;
    for (int off = 1; off <= NPU; off++) begin
      sum = int'(last) + off;
      if (sum >= NPU) sum = sum - NPU;
      idx = LW'(sum);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pu_mem_arb.sv
// Two-state arbiter granting one PU at a time to a single memory port, with
// round-robin fairness and a BUSY timeout that reports err to the owner.
module pu_mem_arb
  import pu_pkg::*;
#(
  parameter int NPU = NPU_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TO  = TO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPU-1:0]    req,
  input  logic [NPU-1:0]    we,
  input  logic [NPU*AW-1:0] addr,
  input  logic [NPU*DW-1:0] wdata,
  output logic [NPU-1:0]    gnt,
  output logic [NPU-1:0]    ack,
  output logic [NPU-1:0]    err,
  output logic [DW-1:0]     rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int LW = (NPU > 1) ? $clog2(NPU) : 1;
  localparam int CW = (TO > 1) ? $clog2(TO + 1) : 1;

  state_t        state;
  logic [LW-1:0] last;
  logic [LW-1:0] owner;
  logic [CW-1:0] cnt;
  logic          armed;

  logic [NPU-1:0] win;
  logic           win_valid;
  logic [LW-1:0]  win_idx;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;

  rr_pick #(
    .NPU (NPU),
    .LW  (LW)
  ) u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NPU; i++) begin
      if (win[i]) begin
        win_idx   = LW'(i);
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // armed holds off arbitration for the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= LW'(NPU - 1);
      owner     <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      armed <= 1'b1;
      ack   <= '0;
      err   <= '0;
      case (state)
        IDLE: begin
          if (armed && win_valid) begin
            state     <= BUSY;
            gnt       <= win;
            owner     <= win_idx;
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt       <= '0;
          end
        end
        BUSY: begin
          // mem_ack is checked first so a completion on the timeout edge wins
          if (mem_ack) begin
            ack     <= gnt;
            if (!mem_we) rdata <= mem_rdata;
            last    <= owner;
            mem_req <= 1'b0;
            gnt     <= '0;
            state   <= IDLE;
          end else if (cnt == CW'(TO - 1)) begin
            err     <= gnt;
            last    <= owner;
            mem_req <= 1'b0;
            gnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_mem_arb.sv
// Randomized bench for pu_mem_arb with a transaction-level reference model.
module tb_pu_mem_arb;
  import pu_pkg::*;

  localparam int NPU = NPU_DEF;
  localparam int AW  = AW_DEF;
  localparam int DW  = DW_DEF;
  localparam int TO  = TO_DEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NPU-1:0]    req = '0;
  logic [NPU-1:0]    we = '0;
  logic [NPU*AW-1:0] addr = '0;
  logic [NPU*DW-1:0] wdata = '0;
  logic [NPU-1:0]    gnt, ack, err;
  logic [DW-1:0]     rdata;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;

  pu_mem_arb #(.NPU(NPU), .AW(AW), .DW(DW), .TO(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // scoreboard state
  int             n_checks = 0;
  int             n_pass   = 0;
  int             last_m;
  logic [DW-1:0]  rdata_m;
  bit             stray_pending;
  int             gnt_obs;
  logic [31:0]    exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NPU-1:0] onehot(input int i);
    logic [NPU-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Spec rule: first requesting PU scanning from (last+1) mod NPU.
  function automatic int pick(input logic [NPU-1:0] rq, input int last);
    for (int off = 1; off <= NPU; off++) begin
      int i;
      i = (last + off) % NPU;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic randomize_pu();
    for (int i = 0; i < NPU; i++) begin
      we[i]              = 1'($urandom_range(0, 1));
      addr[i*AW +: AW]   = AW'($urandom);
      wdata[i*DW +: DW]  = DW'($urandom);
    end
  endtask

  // Drive one arbitration round starting at a negedge with the DUT idle.
  // lat = BUSY edge on which mem_ack is sampled; lat > TO means no ack.
  task automatic do_txn(input int lat, input logic [NPU-1:0] rq, input logic [DW-1:0] rd_val,
                        input bit perturb, input bit drop_owner);
    int            w;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            done;
    req = rq;
    mem_ack = stray_pending;
    stray_pending = 0;
    w = pick(rq, last_m);
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    if (w >= 0) begin
      exp_we    = we[w];
      exp_addr  = addr[w*AW +: AW];
      exp_wdata = wdata[w*DW +: DW];
    end
    @(negedge clk);
    mem_ack = 1'b0;
    gnt_obs = -1;
    for (int i = 0; i < NPU; i++) if (gnt[i]) gnt_obs = i;
    if (w < 0) begin
      check("idle_no_grant", 32'({mem_req, gnt, ack, err}), 32'(0));
      return;
    end
    check("grant", 32'({mem_req, gnt, mem_we, mem_addr, mem_wdata}),
          32'({1'b1, onehot(w), exp_we, exp_addr, exp_wdata}));
    check("grant_no_pulse", 32'({ack, err}), 32'(0));
    done = 0;
    for (int k = 1; k <= TO && !done; k++) begin
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rd_val : DW'($urandom);
      if (perturb) begin
        randomize_pu();
        for (int i = 0; i < NPU; i++) if (i != w) req[i] = 1'($urandom_range(0, 1));
      end
      if (drop_owner) req[w] = 1'b0;
      @(negedge clk);
      if (k == lat) begin
        if (!exp_we) rdata_m = rd_val;
        check("ack_pulse", 32'({ack, err}), 32'({onehot(w), {NPU{1'b0}}}));
        check("ack_release", 32'({mem_req, gnt}), 32'(0));
        check("ack_rdata", 32'(rdata), 32'(rdata_m));
        done = 1;
      end else if (k == TO) begin
        check("timeout_err", 32'({ack, err}), 32'({{NPU{1'b0}}, onehot(w)}));
        check("timeout_release", 32'({mem_req, gnt}), 32'(0));
        check("timeout_rdata", 32'(rdata), 32'(rdata_m));
        done = 1;
      end else begin
        check("busy_hold", 32'({mem_req, gnt, mem_we, mem_addr, mem_wdata}),
              32'({1'b1, onehot(w), exp_we, exp_addr, exp_wdata}));
        check("busy_no_pulse", 32'({ack, err}), 32'(0));
      end
    end
    mem_ack = 1'b0;
    last_m = w;
    if (lat == TO + 1) stray_pending = 1;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic reset_check(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_ctl"}, 32'({mem_req, gnt, ack, err, mem_we}), 32'(0));
    check({tag, "_data"}, 32'({mem_addr, rdata}), 32'(0));
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(0));
    last_m = NPU - 1;
    rdata_m = '0;
    stray_pending = 0;
    mem_ack = 1'b0;
  endtask

  task automatic release_reset(input logic [NPU-1:0] rq);
    @(negedge clk);
    req = rq;
    rst = 1'b1;
    @(negedge clk);
    check("first_edge_no_grant", 32'({mem_req, gnt, ack, err}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rand;
    reset_check("por");
    randomize_pu();
    release_reset(4'hF);

    // round-robin order with all four requesting
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int t = 0; t < 5; t++) begin
      do_txn(1, 4'hF, DW'($urandom), 0, 0);
      check("rr_order", 32'(gnt_obs), exp_q.pop_front());
    end

    // PU2 read at 0x3C, completion on the 3rd BUSY cycle
    randomize_pu();
    we[2] = 1'b0;
    addr[2*AW +: AW] = 8'h3C;
    do_txn(3, 4'b0100, 16'hBEEF, 0, 0);
    check("pu2_read_rdata", 32'(rdata), 32'h0000BEEF);

    // PU1 write that never completes, then PU1 loses to PU3
    randomize_pu();
    we[1] = 1'b1;
    do_txn(TO + 5, 4'b0010, '0, 0, 0);
    randomize_pu();
    do_txn(2, 4'b1010, DW'($urandom), 0, 0);
    check("after_timeout_winner", 32'(gnt_obs), 32'd3);

    // ack on the timeout edge
    randomize_pu();
    do_txn(TO, 4'b0101, DW'($urandom), 0, 0);

    // PU3 wanders during BUSY and drops req
    randomize_pu();
    do_txn(4, 4'b1000, DW'($urandom), 1, 1);

    // mem_ack one edge after timeout lands in IDLE and must be ignored
    randomize_pu();
    do_txn(TO + 1, 4'b0001, '0, 0, 0);
    do_txn(1, 4'b0000, '0, 0, 0);

    // reset in the middle of a transaction
    randomize_pu();
    req = 4'b0110;
    @(negedge clk);
    check("pre_reset_busy", 32'(mem_req), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_check("mid_busy");
    release_reset(4'hF);
    do_txn(1, 4'hF, DW'($urandom), 0, 0);
    check("post_reset_pu0", 32'(gnt_obs), 32'd0);

    // random traffic
    n_rand = 60;
    for (int t = 0; t < n_rand; t++) begin
      randomize_pu();
      do_txn($urandom_range(1, TO + 2), NPU'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
